axi4lite_bram_ctrl: RTL and testbench

//  AXI4-Lite slave that initiates accesses on a single BRAM port (A) of the MicroBlaze-side BRAM block.

---
 rtl/axi4lite_bram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_axi4lite_bram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_bram_ctrl.sv
// rtl/axi4lite_bram_ctrl.sv - AXI4-Lite slave bridging single transactions onto BRAM port A
//
// Purpose : accepts one AXI4-Lite read or write at a time and turns it into
//           registered BRAM EN/WEN/Addr/Dout strobes; BRAM read data is
//           returned as RDATA. Addresses outside C_BASEADDR..+C_MEMSIZE-1
//           get SLVERR and never touch the BRAM.
// Build option : define BRAM_RD_PIPE_EN when the BRAM primitive output
//           register is enabled; adds one read wait state (read latency 4).
// Ports   : Clk, Rst                      clock, async active-high reset
//           S_AXI_AW*/W*/B*               write address, data, response
//           S_AXI_AR*/R*                  read address, data/response
//           BRAM_Rst_A, BRAM_Clk_A        pass-through of Rst / Clk
//           BRAM_EN_A, BRAM_WEN_A[0:3]    registered enable / byte write enables
//           BRAM_Addr_A[0:31]             byte offset from C_BASEADDR, word aligned
//           BRAM_Dout_A[0:31]             write data (bit 0 = WDATA[31])
//           BRAM_Din_A[0:31]              read data, one cycle after EN
module axi4lite_bram_ctrl #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [32:0] C_MEMSIZE  = 33'h0_0000_2000,
  parameter int          C_NUM_WE   = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [31:0]         S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [C_NUM_WE-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [31:0]         S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic                BRAM_Rst_A,
  output logic                BRAM_Clk_A,
  output logic                BRAM_EN_A,
  output logic [0:C_NUM_WE-1] BRAM_WEN_A,
  output logic [0:31]         BRAM_Addr_A,
  output logic [0:31]         BRAM_Dout_A,
  input  logic [0:31]         BRAM_Din_A
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_RESP,
    RD_ISSUE,
`ifdef BRAM_RD_PIPE_EN
    RD_PIPE,
`endif
    RD_CAPT,
    RD_RESP
  } state_t;

  state_t      state, next_state;
  logic        prefer_wr;
  logic        wr_elig, rd_elig;
  logic        wr_accept, rd_accept;
  logic [32:0] wr_off, rd_off;
  logic        wr_in_range, rd_in_range;

  assign BRAM_Rst_A = Rst;
  assign BRAM_Clk_A = Clk;

  // 33-bit subtraction: bit 32 set means the address lies below the base.
  assign wr_off      = {1'b0, S_AXI_AWADDR} - {1'b0, C_BASEADDR};
  assign rd_off      = {1'b0, S_AXI_ARADDR} - {1'b0, C_BASEADDR};
  assign wr_in_range = !wr_off[32] && (wr_off < C_MEMSIZE);
  assign rd_in_range = !rd_off[32] && (rd_off < C_MEMSIZE);

  assign wr_elig = S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_elig = S_AXI_ARVALID;

  // READYs are combinational accept strobes, forced low while reset is held.
  assign S_AXI_AWREADY = wr_accept && !Rst;
  assign S_AXI_WREADY  = wr_accept && !Rst;
  assign S_AXI_ARREADY = rd_accept && !Rst;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || prefer_wr)) begin
          wr_accept  = 1'b1;
          next_state = WR_RESP;
        end else if (rd_elig) begin
          rd_accept  = 1'b1;
          next_state = rd_in_range ? RD_ISSUE : RD_RESP;
        end
      end
      WR_RESP:  if (S_AXI_BREADY) next_state = IDLE;
`ifdef BRAM_RD_PIPE_EN
      RD_ISSUE: next_state = RD_PIPE;
      RD_PIPE:  next_state = RD_CAPT;
`else
      RD_ISSUE: next_state = RD_CAPT;
`endif
      RD_CAPT:  next_state = RD_RESP;
      RD_RESP:  if (S_AXI_RREADY) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prefer_wr    <= 1'b1;
      BRAM_EN_A    <= 1'b0;
      BRAM_WEN_A   <= '0;
      BRAM_Addr_A  <= '0;
      BRAM_Dout_A  <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      // EN/WEN are one-cycle pulses; Addr/Dout simply hold their last value.
      BRAM_EN_A  <= 1'b0;
      BRAM_WEN_A <= '0;

      if (wr_accept) begin
        prefer_wr    <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        if (wr_in_range) begin
          BRAM_EN_A   <= 1'b1;
          BRAM_WEN_A  <= S_AXI_WSTRB;
          BRAM_Addr_A <= wr_off[31:0] & 32'hFFFF_FFFC;
          BRAM_Dout_A <= S_AXI_WDATA;
          S_AXI_BRESP <= RESP_OKAY;
        end else begin
          S_AXI_BRESP <= RESP_SLVERR;
        end
      end

      if (rd_accept) begin
        prefer_wr <= 1'b1;
        if (rd_in_range) begin
          BRAM_EN_A   <= 1'b1;
          BRAM_Addr_A <= rd_off[31:0] & 32'hFFFF_FFFC;
        end else begin
          // Decode error answers immediately without a BRAM access.
          S_AXI_RVALID <= 1'b1;
          S_AXI_RRESP  <= RESP_SLVERR;
          S_AXI_RDATA  <= '0;
        end
      end

      if (state == RD_CAPT) begin
        S_AXI_RDATA  <= BRAM_Din_A;
        S_AXI_RRESP  <= RESP_OKAY;
        S_AXI_RVALID <= 1'b1;
      end

      if (state == WR_RESP && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
        S_AXI_BRESP  <= RESP_OKAY;
      end

      if (state == RD_RESP && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
        S_AXI_RRESP  <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_bram_ctrl.sv
// tb/tb_axi4lite_bram_ctrl.sv - scoreboard bench for axi4lite_bram_ctrl with a BRAM model
`timescale 1ns/1ps
module tb_axi4lite_bram_ctrl;
`ifdef BRAM_RD_PIPE_EN
  localparam int RD_LAT = 4;
`else
  localparam int RD_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        bram_rst, bram_clk, bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr, bram_dout, bram_din;
  logic [3:0]  wen_v;
  logic [31:0] addr_v, dout_v, din_q, din_p, nw;
  logic [31:0] bram_mem [0:2047];
  logic [31:0] ref_mem [0:2047];
  int          en_count = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];

  always #5 clk = ~clk;

  axi4lite_bram_ctrl dut (
    .Clk(clk), .Rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .BRAM_Rst_A(bram_rst), .BRAM_Clk_A(bram_clk), .BRAM_EN_A(bram_en),
    .BRAM_WEN_A(bram_wen), .BRAM_Addr_A(bram_addr), .BRAM_Dout_A(bram_dout),
    .BRAM_Din_A(bram_din)
  );

  // Big-endian port vectors viewed as little-endian words: wen_v[3] = WEN[0].
  assign wen_v  = bram_wen;
  assign addr_v = bram_addr;
  assign dout_v = bram_dout;
`ifdef BRAM_RD_PIPE_EN
  assign bram_din = din_p;
`else
  assign bram_din = din_q;
`endif

  always @(posedge clk) begin
    if (bram_en === 1'b1) begin
      if (wen_v != 4'b0) begin
        nw = bram_mem[addr_v[12:2]];
        for (int k = 0; k < 4; k++) if (wen_v[k]) nw[8*k +: 8] = dout_v[8*k +: 8];
        bram_mem[addr_v[12:2]] <= nw;
      end else begin
        din_q <= bram_mem[addr_v[12:2]];
      end
    end
    din_p <= din_q;
    if (bram_en === 1'b1) en_count <= en_count + 1;
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdelay);
    logic       in_r;
    logic [1:0] e;
    logic [31:0] w;
    int         n, en0;
    in_r = (a < 32'h2000);
    exp_b.push_back(in_r ? 2'b00 : 2'b10);
    if (in_r) begin
      w = ref_mem[a[12:2]];
      for (int k = 0; k < 4; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
      ref_mem[a[12:2]] = w;
    end
    en0 = en_count;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (!(awready && wready)) begin bad++; $display("FAIL wr_accept a=%h got=0 want=1", a); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1) begin bad++; $display("FAIL wr_bvalid_t1 a=%h got=%b want=1", a, bvalid); end
    total++;
    if (in_r) begin
      if ({bram_en, wen_v, addr_v, dout_v} !== {1'b1, s, a & 32'hFFFF_FFFC, d}) begin
        bad++;
        $display("FAIL wr_strobes a=%h got en=%b wen=%b addr=%h dout=%h want en=1 wen=%b addr=%h dout=%h",
                 a, bram_en, wen_v, addr_v, dout_v, s, a & 32'hFFFF_FFFC, d);
      end
    end else if (bram_en !== 1'b0) begin
      bad++; $display("FAIL wr_oor_en a=%h got=%b want=0", a, bram_en);
    end
    if (bdelay > 0) begin araddr = a; arvalid = 1'b1; end
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      total++;
      if ({bvalid, bresp, arready, awready} !== {1'b1, exp_b[0], 2'b00}) begin
        bad++;
        $display("FAIL wr_stall cyc=%0d got bvalid=%b bresp=%b arready=%b want 1 %b 0",
                 i, bvalid, bresp, arready, exp_b[0]);
      end
    end
    arvalid = 1'b0; bready = 1'b1;
    e = exp_b.pop_front();
    total++;
    if ({bvalid, bresp} !== {1'b1, e}) begin
      bad++; $display("FAIL wr_bresp a=%h got=%b/%b want=1/%b", a, bvalid, bresp, e);
    end
    @(negedge clk);
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL wr_bvalid_clear got=%b want=0", bvalid); end
    total++;
    if (en_count !== en0 + (in_r ? 1 : 0)) begin
      bad++; $display("FAIL wr_en_pulses a=%h got=%0d want=%0d", a, en_count - en0, in_r ? 1 : 0);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay);
    logic  in_r, got;
    rexp_t e;
    int    n, en0, lat;
    in_r = (a < 32'h2000);
    e.data = in_r ? ref_mem[a[12:2]] : 32'h0;
    e.resp = in_r ? 2'b00 : 2'b10;
    exp_r.push_back(e);
    lat = in_r ? RD_LAT : 1;
    en0 = en_count;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (!arready) begin bad++; $display("FAIL rd_accept a=%h got=0 want=1", a); end
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        arvalid = 1'b0;
        total++;
        if (in_r ? ({bram_en, wen_v, addr_v} !== {1'b1, 4'b0, a & 32'hFFFF_FFFC}) : (bram_en !== 1'b0)) begin
          bad++;
          $display("FAIL rd_strobes a=%h got en=%b wen=%b addr=%h want en=%b", a, bram_en, wen_v, addr_v, in_r);
        end
      end
      if (rvalid === 1'b1) got = 1'b1;
    end
    total++;
    if (n !== lat) begin bad++; $display("FAIL rd_latency a=%h got=%0d want=%0d", a, n, lat); end
    for (int i = 0; i < rdelay; i++) begin
      if (i == 0) begin araddr = a; arvalid = 1'b1; end
      @(negedge clk);
      total++;
      if ({rvalid, rdata, rresp, arready} !== {1'b1, exp_r[0].data, exp_r[0].resp, 1'b0}) begin
        bad++;
        $display("FAIL rd_stall cyc=%0d got rvalid=%b rdata=%h rresp=%b arready=%b want 1 %h %b 0",
                 i, rvalid, rdata, rresp, arready, exp_r[0].data, exp_r[0].resp);
      end
    end
    arvalid = 1'b0; rready = 1'b1;
    e = exp_r.pop_front();
    total++;
    if ({rvalid, rdata, rresp} !== {1'b1, e.data, e.resp}) begin
      bad++; $display("FAIL rd_data a=%h got=%h/%b want=%h/%b", a, rdata, rresp, e.data, e.resp);
    end
    @(negedge clk);
    rready = 1'b0;
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_clear got=%b want=0", rvalid); end
    total++;
    if (en_count !== en0 + (in_r ? 1 : 0)) begin
      bad++; $display("FAIL rd_en_pulses a=%h got=%0d want=%0d", a, en_count - en0, in_r ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b0) begin
      bad++; $display("FAIL rst_ready got=%b want=000", {awready, wready, arready});
    end
    total++;
    if ({bvalid, bresp, rvalid, rresp, rdata} !== 38'b0) begin
      bad++; $display("FAIL rst_resp got bv=%b br=%b rv=%b rr=%b rd=%h want 0", bvalid, bresp, rvalid, rresp, rdata);
    end
    total++;
    if ({bram_en, wen_v, addr_v, dout_v} !== 69'b0) begin
      bad++; $display("FAIL rst_bram got en=%b wen=%b addr=%h dout=%h want 0", bram_en, wen_v, addr_v, dout_v);
    end
    total++;
    if (bram_rst !== 1'b1) begin bad++; $display("FAIL rst_passthru got=%b want=1", bram_rst); end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    axi_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    axi_read(32'h0000_0010, 0);
    axi_write(32'h0000_1FFC, 32'h0BAD_CAFE, 4'hF, 0);
    axi_read(32'h0000_1FFC, 0);
  endtask

  task automatic test_partial_strobe;
    axi_write(32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(32'h0000_0020, 32'h1122_3344, 4'b0001, 0);
    axi_read(32'h0000_0020, 0);
    axi_write(32'h0000_0024, 32'h5566_7788, 4'hF, 0);
    axi_write(32'h0000_0026, 32'h1234_5678, 4'b0000, 0);
    axi_read(32'h0000_0024, 0);
  endtask

  task automatic test_arbitration;
    int code, count, n;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ref_mem[16] = 32'hA5A5_5A5A;
    awaddr = 32'h40; wdata = 32'hA5A5_5A5A; wstrb = 4'hF; araddr = 32'h40;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    code = 0; count = 0; n = 0;
    while (count < 3 && n < 60) begin
      #1;
      if (awready && wready && !arready) begin code = code * 4 + 1; count++; end
      else if (arready && !awready && !wready) begin code = code * 4 + 2; count++; end
      else if (arready || awready || wready) begin code = code * 4 + 3; count++; end
      @(negedge clk);
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (4) @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    total++;
    if (count !== 3 || code !== 25) begin
      bad++; $display("FAIL arb_order got count=%0d code=%0d want count=3 code=25 (W,R,W)", count, code);
    end
  endtask

  task automatic test_out_of_range;
    axi_read(32'h0000_2000, 0);
    axi_write(32'h0000_3000, 32'h0F0F_0F0F, 4'hF, 0);
    axi_read(32'h0000_1FFC, 0);
  endtask

  task automatic test_stall;
    axi_write(32'h0000_0030, 32'hCAFE_F00D, 4'hF, 5);
    axi_read(32'h0000_0030, 5);
    axi_read(32'h0000_2004, 5);
  endtask

  task automatic test_reset_mid_read;
    logic seen;
    int   n;
    @(negedge clk);
    araddr = 32'h10; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({rvalid, bram_en, arready} !== 3'b0) begin
      bad++; $display("FAIL rstmid_outputs got rvalid=%b en=%b arready=%b want 000", rvalid, bram_en, arready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    rready = 1'b1;
    repeat (6) begin @(negedge clk); if (rvalid !== 1'b0) seen = 1'b1; end
    rready = 1'b0;
    total++;
    if (seen) begin bad++; $display("FAIL rstmid_no_resp got rvalid=1 want=0"); end
    axi_read(32'h0000_0010, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    test_reset;
    test_write_read;
    test_partial_strobe;
    test_arbitration;
    test_out_of_range;
    test_stall;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
